// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
//   2^INDEX_W blocks of 4 bytes. The byte address is split as {tag, index, offset[1:0]}.
//   Requests are not latched; the CPU holds its inputs stable while BUSYWAIT is high.
// Ports:
//   CLK, RESET (async, active low)
//   CPU side : READ, WRITE, ADDRESS[7:0], WRITEDATA[7:0] -> READDATA[7:0], BUSYWAIT
//   Mem side : MEM_READ, MEM_WRITE, MEM_ADDRESS[5:0], MEM_WRITEDATA[31:0]
//              <- MEM_READDATA[31:0], MEM_BUSYWAIT
module dcache #(
  parameter int INDEX_W = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);
  localparam int TAG_W = 6 - INDEX_W;
  localparam int NBLK  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_FETCH, UPDATE} state_t;
  state_t state, state_nxt;

  logic [NBLK-1:0]            valid, dirty;
  logic [NBLK-1:0][TAG_W-1:0] tags;
  logic [NBLK-1:0][31:0]      data;

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [31:0]        blk;
  logic               hit, req, write_hit;

  assign offset    = ADDRESS[1:0];
  assign index     = ADDRESS[INDEX_W+1:2];
  assign tag       = ADDRESS[7:INDEX_W+2];
  assign blk       = data[index];
  assign hit       = valid[index] && (tags[index] == tag);
  assign req       = READ || WRITE;
  // A simultaneous READ and WRITE behaves as a write.
  assign write_hit = (state == IDLE) && WRITE && hit;

  // Invalid blocks read as zero so stale array contents never leak out after reset.
  assign READDATA = (READ && valid[index]) ? blk[{offset, 3'b000} +: 8] : 8'h00;
  // Gated by RESET so a request held across reset does not stall the CPU during it.
  assign BUSYWAIT = RESET && req && !((state == IDLE) && hit);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory-side outputs decode only the state register and held inputs,
  // so they move only at clock edges or on reset.
  always_comb begin
    state_nxt     = state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      IDLE: begin
        if (req && !hit) state_nxt = dirty[index] ? WRITE_BACK : MEM_FETCH;
      end
      WRITE_BACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[index], index};
        MEM_WRITEDATA = blk;
        if (!MEM_BUSYWAIT) state_nxt = MEM_FETCH;
      end
      MEM_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag, index};
        if (!MEM_BUSYWAIT) state_nxt = UPDATE;
      end
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (write_hit) begin
      dirty[index] <= 1'b1;
    end
  end

  // Data and tags need no reset; valid bits mask them.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data[index] <= MEM_READDATA;
      tags[index] <= tag;
    end else if (write_hit) begin
      data[index][{offset, 3'b000} +: 8] <= WRITEDATA;
    end
  end
endmodule

// File: tb/tb_dcache.sv
module tb_dcache;
  logic        CLK, RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  int total = 0;
  int bad   = 0;

  dcache #(.INDEX_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Memory finishes the fetch: present data, drop busy for one edge, then UPDATE edge.
  task automatic mem_done(input logic [31:0] blkdata);
    MEM_READDATA = blkdata;
    MEM_BUSYWAIT = 1'b0;
    tick();                 // MEM_FETCH -> UPDATE
    MEM_BUSYWAIT = 1'b1;
    tick();                 // UPDATE -> IDLE, block loaded
    #1;
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    MEM_BUSYWAIT = 1'b1; MEM_READDATA = 32'h0;
    tick(); tick();
    chk("rst_busywait", BUSYWAIT, 0);
    chk("rst_mem_read", MEM_READ, 0);
    chk("rst_mem_write", MEM_WRITE, 0);
    chk("rst_mem_addr", MEM_ADDRESS, 0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 0);
    chk("rst_readdata", READDATA, 0);
    RESET = 1'b1;
    tick();

    // Clean miss on 0x00
    READ = 1'b1; ADDRESS = 8'h00; #1;
    chk("miss0_busy", BUSYWAIT, 1);
    chk("miss0_memrd_idle", MEM_READ, 0);
    tick();
    chk("miss0_memrd", MEM_READ, 1);
    chk("miss0_memwr", MEM_WRITE, 0);
    chk("miss0_addr", MEM_ADDRESS, 6'h00);
    chk("miss0_busy_fetch", BUSYWAIT, 1);
    mem_done(32'h44332211);
    chk("fill0_rd", READDATA, 8'h11);
    chk("fill0_busy", BUSYWAIT, 0);
    chk("fill0_memrd", MEM_READ, 0);

    // Hit path
    ADDRESS = 8'h02; #1;
    chk("hit02_rd", READDATA, 8'h33);
    chk("hit02_busy", BUSYWAIT, 0);
    tick();
    chk("hit02_memrd", MEM_READ, 0);
    ADDRESS = 8'h03; #1;
    chk("hit03_rd", READDATA, 8'h44);

    // Write hit, then dirty eviction
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h01; WRITEDATA = 8'hAA; #1;
    chk("wr01_busy", BUSYWAIT, 0);
    tick();
    WRITE = 1'b0; READ = 1'b1; #1;
    chk("rd01_after_wr", READDATA, 8'hAA);
    ADDRESS = 8'h20; #1;
    chk("miss20_busy", BUSYWAIT, 1);
    tick();
    chk("wb_memwr", MEM_WRITE, 1);
    chk("wb_memrd", MEM_READ, 0);
    chk("wb_addr", MEM_ADDRESS, 6'h00);
    chk("wb_wdata", MEM_WRITEDATA, 32'h4433AA11);
    tick();
    chk("wb_hold_memwr", MEM_WRITE, 1);
    chk("wb_hold_addr", MEM_ADDRESS, 6'h00);
    MEM_BUSYWAIT = 1'b0;
    tick();
    MEM_BUSYWAIT = 1'b1;
    chk("wb2f_memwr", MEM_WRITE, 0);
    chk("wb2f_memrd", MEM_READ, 1);
    chk("wb2f_addr", MEM_ADDRESS, 6'h08);
    mem_done(32'hDDCCBBAA);
    chk("fill20_rd", READDATA, 8'hAA);
    chk("fill20_busy", BUSYWAIT, 0);
    ADDRESS = 8'h23; #1;
    chk("hit23_rd", READDATA, 8'hDD);

    // Write miss allocate to 0x45 (index 1, tag 2)
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h45; WRITEDATA = 8'h5C; #1;
    chk("wmiss45_busy", BUSYWAIT, 1);
    tick();
    chk("wmiss45_memrd", MEM_READ, 1);
    chk("wmiss45_memwr", MEM_WRITE, 0);
    chk("wmiss45_addr", MEM_ADDRESS, 6'h11);
    mem_done(32'h87654321);
    chk("wmiss45_hit_busy", BUSYWAIT, 0);
    tick();
    WRITE = 1'b0; READ = 1'b1; #1;
    chk("rd45", READDATA, 8'h5C);
    ADDRESS = 8'h05; #1;                   // same index, tag 0 -> dirty eviction
    tick();
    chk("evict45_memwr", MEM_WRITE, 1);
    chk("evict45_addr", MEM_ADDRESS, 6'h11);
    chk("evict45_wdata", MEM_WRITEDATA, 32'h87655C21);
    MEM_BUSYWAIT = 1'b0;
    tick();
    MEM_BUSYWAIT = 1'b1;
    chk("evict45_fetch_addr", MEM_ADDRESS, 6'h01);
    chk("evict45_fetch_rd", MEM_READ, 1);

    // Reset mid-fetch takes effect without a clock edge
    #2;
    RESET = 1'b0; #1;
    chk("rstmid_memrd", MEM_READ, 0);
    chk("rstmid_busy", BUSYWAIT, 0);
    chk("rstmid_addr", MEM_ADDRESS, 0);
    tick(); tick();
    RESET = 1'b1;
    ADDRESS = 8'h00; #1;
    chk("postrst_busy", BUSYWAIT, 1);
    chk("postrst_rd", READDATA, 0);
    tick();
    chk("postrst_memrd", MEM_READ, 1);
    chk("postrst_memwr", MEM_WRITE, 0);
    chk("postrst_addr", MEM_ADDRESS, 6'h00);

    // Slow memory: busy for 5 cycles, nothing moves
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("slow_memrd", MEM_READ, 1);
      chk("slow_addr", MEM_ADDRESS, 6'h00);
      chk("slow_busy", BUSYWAIT, 1);
    end
    mem_done(32'h0BADF00D);
    chk("slow_fill_rd", READDATA, 8'h0D);
    chk("slow_fill_busy", BUSYWAIT, 0);
    ADDRESS = 8'h03; #1;
    chk("slow_hit03", READDATA, 8'h0B);

    // READ and WRITE together behave as a write
    WRITE = 1'b1; ADDRESS = 8'h01; WRITEDATA = 8'h77; #1;
    chk("rw_busy", BUSYWAIT, 0);
    tick();
    WRITE = 1'b0; #1;
    chk("rw_rd01", READDATA, 8'h77);
    READ = 1'b0;
    tick();
    chk("idle_busy", BUSYWAIT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
